// File: rtl/ase_hssi_log_arbiter.sv
// ase_hssi_log_arbiter
// Shares one HSSI transaction logger's message-injection port among NUM_REQ
// requesters. Requesters are served round-robin. Each accepted message is
// registered onto log_* and held until the logger side accepts it. An
// optional idle gap can be forced after each message. A saturating counter
// tracks how many messages the logger has taken.
//
// Handshake rules:
//   Requester side: a message moves when req_valid[i] && req_ready[i].
//   req_ready is one-hot or zero and may depend on req_valid. Requesters
//   must not make req_valid depend on req_ready.
//   Logger side: a message moves when log_string_en && log_ready. log_msg,
//   log_timestamp_en and log_src stay stable while log_ready is low.
//
// Ports:
//   clk, SoftReset_n      clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake
//   req_msg, req_ts_en    per-requester payload and timestamp request
//   log_string_en, log_timestamp_en, log_msg, log_src   message toward logger
//   log_ready             logger accepts the current message this cycle
//   msg_count             messages taken by the logger, saturating
//   busy                  FSM not idle
//   state_dbg             raw FSM state (0 IDLE, 1 SEND, 2 GAP)
module ase_hssi_log_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int MSG_W      = 64,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     SoftReset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*MSG_W-1:0] req_msg,
  input  logic [NUM_REQ-1:0]       req_ts_en,
  output logic                     log_string_en,
  output logic                     log_timestamp_en,
  output logic [MSG_W-1:0]         log_msg,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] log_src,
  input  logic                     log_ready,
  output logic [CNT_W-1:0]         msg_count,
  output logic                     busy,
  output logic [1:0]               state_dbg
);

  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [7:0]       gap_cnt, gap_cnt_next;
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] winner;
  logic             found;
  logic             window_open;
  logic             accept;
  logic             log_done;
  int               idx;

  // Round-robin scan starting just after the last winner.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx[SRC_W-1:0];
      end
    end
  end

  assign log_done = (state == SEND) && log_ready;

  // A new message may only enter when the output register is free or is
  // being drained this very cycle without a gap to follow. Held closed
  // during reset so every output reads zero.
  always_comb begin
    window_open = 1'b0;
    if (SoftReset_n) begin
      if (state == IDLE)
        window_open = 1'b1;
      else if (log_done && (GAP_CYCLES == 0))
        window_open = 1'b1;
    end
  end

  assign accept = found && window_open;

  always_comb begin
    req_ready = '0;
    if (accept)
      req_ready[winner] = 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_next   = state;
    gap_cnt_next = gap_cnt;
    case (state)
      IDLE: begin
        if (accept)
          state_next = SEND;
      end
      SEND: begin
        if (log_ready) begin
          if (accept) begin
            state_next = SEND;
          end else if (GAP_CYCLES == 0) begin
            state_next = IDLE;
          end else begin
            state_next   = GAP;
            gap_cnt_next = 8'(GAP_CYCLES);
          end
        end
      end
      GAP: begin
        // Leaving at count 1 yields exactly GAP_CYCLES idle cycles.
        if (gap_cnt <= 8'd1) begin
          state_next   = IDLE;
          gap_cnt_next = 8'd0;
        end else begin
          gap_cnt_next = gap_cnt - 8'd1;
        end
      end
      default: begin
        state_next   = IDLE;
        gap_cnt_next = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      state   <= IDLE;
      gap_cnt <= 8'd0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_cnt_next;
    end
  end

  // Message register and round-robin pointer.
  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      log_msg          <= '0;
      log_timestamp_en <= 1'b0;
      log_src          <= '0;
      rr_ptr           <= SRC_W'(NUM_REQ - 1);
    end else if (accept) begin
      log_msg          <= req_msg[int'(winner)*MSG_W +: MSG_W];
      log_timestamp_en <= req_ts_en[winner];
      log_src          <= winner;
      rr_ptr           <= winner;
    end
  end

  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n)
      msg_count <= '0;
    else if (log_done && (msg_count != {CNT_W{1'b1}}))
      msg_count <= msg_count + 1'b1;
  end

  assign log_string_en = (state == SEND);
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

endmodule

// File: doc/ase_hssi_log_arbiter.md
Name: ase_hssi_log_arbiter

Overview:
- Shares a single HSSI transaction logger's message-injection port among NUM_REQ requesters, such as per-lane monitors or MAC/PCS checkers on one channel.
- Round-robin grant; each accepted message becomes a registered log_string_en strobe with payload, timestamp flag and source index, held until the logger side accepts it.
- Optional enforced idle gap between messages; saturating count of issued messages.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
MSG_W, 64, message payload width in bits
GAP_CYCLES, 0, idle cycles forced after each accepted message (0..255)
CNT_W, 16, width of issued-message counter

Ports:
clk  input  1  clock
SoftReset_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester message valid
req_ready  output  NUM_REQ  per-requester accept (one-hot or zero)
req_msg  input  NUM_REQ*MSG_W  payloads, requester i at bits [i*MSG_W +: MSG_W]
req_ts_en  input  NUM_REQ  per-requester timestamp request
log_string_en  output  1  message valid toward logger
log_timestamp_en  output  1  timestamp flag for current message
log_msg  output  MSG_W  current message payload
log_src  output  max(1,$clog2(NUM_REQ))  index of requester that owns the current message
log_ready  input  1  logger side accepts the current message this cycle
msg_count  output  CNT_W  messages accepted by the logger side, saturating
busy  output  1  state != IDLE

Behaviour:
- Reset (async assert, sync deassert): all outputs are 0; state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 has priority first; gap counter is 0.
- States:
  - IDLE: no message pending.
  - SEND: log_string_en=1, waiting for log_ready.
  - GAP: counting down the idle gap.
- Accept window is open when state==IDLE, or when state==SEND && log_ready && GAP_CYCLES==0. The window is never open in GAP.
- Arbitration, combinational:
  - Winner is the first i with req_valid[i]=1, scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - req_ready[winner]=1 only while the window is open. All other req_ready bits are 0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- On accept, i.e. req_valid[w] && req_ready[w]:
  - Next cycle: log_msg=req_msg[w], log_timestamp_en=req_ts_en[w], log_src=w, log_string_en=1.
  - rr_ptr updates to w.
  - Latency from accept to log_string_en is 1 cycle.
- SEND:
  - log_msg, log_timestamp_en and log_src are held stable while log_ready=0.
  - On log_ready:
    - msg_count increments, saturating at 2^CNT_W-1.
    - With a new accept in the same cycle (GAP_CYCLES==0), stay in SEND with the new payload. This gives back-to-back throughput of one message per cycle.
    - With GAP_CYCLES==0 and no new accept, go to IDLE and drop log_string_en.
    - With GAP_CYCLES>0, load the counter with GAP_CYCLES, go to GAP and drop log_string_en.
- GAP: decrement each cycle; when the counter is 1, go to IDLE. This gives exactly GAP_CYCLES cycles with log_string_en=0 before the next accept cycle.
- Requester withdrawing req_valid before accept: allowed; nothing is captured.
- A requester holding req_valid continuously is granted at most once per NUM_REQ accepts while others are requesting.
- Reset mid-SEND: the pending message is discarded, msg_count is not incremented, and all outputs return to reset values immediately.
- NUM_REQ==1: log_src is 1 bit, always 0.

Test Plan:
1. Single request: NUM_REQ=4, req_valid=4'b0100, req_msg[2]=64'hDEAD_BEEF_0000_0002, req_ts_en[2]=1, log_ready=1. Required: req_ready=4'b0100 for 1 cycle; next cycle log_string_en=1, log_src=2, log_timestamp_en=1, log_msg equals payload; msg_count=1.
2. Fairness: all four req_valid held high for 8 accepts, log_ready=1, GAP_CYCLES=0. Required: log_src sequence 0,1,2,3,0,1,2,3 on consecutive cycles; msg_count=8.
3. Backpressure: log_ready=0 for 5 cycles after the message from requester 1. Required: log_string_en, log_msg and log_src stable; req_ready=0 throughout; single msg_count increment when log_ready rises.
4. Gap: GAP_CYCLES=3, requesters 0 and 3 valid. Required: grant 0, then log_string_en low exactly 3 cycles, then accept of 3; busy=1 during GAP.
5. Reset mid-SEND: assert SoftReset_n=0 while log_string_en=1 with log_ready=0. Required: all outputs 0 asynchronously; msg_count=0; after release, requester 0 wins if all are valid.
6. Saturation: CNT_W=4, 20 accepted messages. Required: msg_count stops at 15.
